// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver with oversampling, 3-sample majority voting,
//   false-start rejection, frame-error reporting and optional parity check.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   : frame = start + DATA_BITS + parity + stop, Parity_Err active
//     undefined : frame = start + DATA_BITS + stop, Parity_Err tied to 0
//
// Parameters
//   CLK_FREQ   : system clock frequency in Hz
//   DATA_BITS  : data bits per frame (5..9), LSB first
//   OVERSAMPLE : sample ticks per bit (even, >= 8)
//
// Ports
//   Clk        : system clock
//   Rst        : synchronous active-high reset
//   baud_set   : 0=9600 1=19200 2=38400 3=57600 4..7=115200, latched at start
//   parity_odd : 1 = odd parity, 0 = even (parity build only)
//   Rs232_Rx   : asynchronous serial input, idle high
//   data_byte  : last correctly received word
//   Rx_Done    : 1-cycle pulse, data_byte valid in the same cycle
//   Frame_Err  : 1-cycle pulse, stop bit voted low
//   Parity_Err : 1-cycle pulse, parity mismatch
//   Rx_Busy    : high whenever the receiver is not idle
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [2:0]           baud_set,
  input  logic                 parity_odd,
  input  logic                 Rs232_Rx,
  output logic [DATA_BITS-1:0] data_byte,
  output logic                 Rx_Done,
  output logic                 Frame_Err,
  output logic                 Parity_Err,
  output logic                 Rx_Busy
);

  function automatic int calc_div(input int baud);
    int d;
    d = CLK_FREQ / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  localparam int DIV_0 = calc_div(9600);
  localparam int DIV_1 = calc_div(19200);
  localparam int DIV_2 = calc_div(38400);
  localparam int DIV_3 = calc_div(57600);
  localparam int DIV_4 = calc_div(115200);

  // The slowest baud always yields the largest divisor.
  localparam int DIV_W  = (DIV_0 > 1) ? $clog2(DIV_0) : 1;
  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0] DIV0_M1 = DIV_W'(DIV_0 - 1);
  localparam logic [DIV_W-1:0] DIV1_M1 = DIV_W'(DIV_1 - 1);
  localparam logic [DIV_W-1:0] DIV2_M1 = DIV_W'(DIV_2 - 1);
  localparam logic [DIV_W-1:0] DIV3_M1 = DIV_W'(DIV_3 - 1);
  localparam logic [DIV_W-1:0] DIV4_M1 = DIV_W'(DIV_4 - 1);

  localparam logic [SAMP_W-1:0] SAMP_A    = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_B    = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] SAMP_C    = SAMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t state, state_nxt;

  logic                 sync_p0, sync_p1, sync_p2;
  logic                 fall_det;
  logic [2:0]           baud_q;
  logic [DIV_W-1:0]     div_m1;
  logic [DIV_W-1:0]     div_cnt;
  logic [SAMP_W-1:0]    samp_cnt;
  logic                 tick;
  logic                 samp_a, samp_b;
  logic                 vote_evt, vote;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 last_bit;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 done_nxt, ferr_nxt;

  // Stage p0/p1: two-flop synchroniser; p2: edge register for the falling edge
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
    end else begin
      sync_p0 <= Rs232_Rx;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign fall_det = sync_p2 & ~sync_p1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      baud_q <= 3'd0;
    end else if (state == IDLE && fall_det) begin
      baud_q <= baud_set;
    end
  end

  always_comb begin
    div_m1 = DIV4_M1;
    case (baud_q)
      3'd0:    div_m1 = DIV0_M1;
      3'd1:    div_m1 = DIV1_M1;
      3'd2:    div_m1 = DIV2_M1;
      3'd3:    div_m1 = DIV3_M1;
      default: div_m1 = DIV4_M1;
    endcase
  end

  assign tick = (div_cnt == div_m1);

  // Counters sit at zero while idle, so they start fresh at start detection.
  always_ff @(posedge Clk) begin
    if (Rst || state == IDLE) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // The first two mid-bit samples are stored; the third is taken live at the vote.
  always_ff @(posedge Clk) begin
    if (tick && samp_cnt == SAMP_A) samp_a <= sync_p1;
    if (tick && samp_cnt == SAMP_B) samp_b <= sync_p1;
  end

  assign vote_evt = (state != IDLE) && tick && (samp_cnt == SAMP_C);
  assign vote     = maj3(samp_a, samp_b, sync_p1);
  assign last_bit = (bit_cnt == BIT_LAST);

  always_ff @(posedge Clk) begin
    if (Rst || state != DATA) begin
      bit_cnt <= '0;
    end else if (vote_evt) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (state == DATA && vote_evt) begin
      shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q;

  always_ff @(posedge Clk) begin
    if (Rst || state == START) begin
      par_err_q <= 1'b0;
    end else if (state == PARITY && vote_evt) begin
      par_err_q <= vote ^ (^shift_reg) ^ parity_odd;
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall_det) state_nxt = START;
      START:   if (vote_evt) state_nxt = vote ? IDLE : DATA;
      DATA:    if (vote_evt && last_bit) state_nxt = AFTER_DATA;
      PARITY:  if (vote_evt) state_nxt = STOP;
      STOP:    if (vote_evt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic perr_nxt;
`endif

  // A low stop bit takes priority over a parity mismatch.
  always_comb begin
    done_nxt = 1'b0;
    ferr_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_nxt = 1'b0;
`endif
    Rx_Busy  = (state != IDLE);
    if (state == STOP && vote_evt) begin
      if (!vote) begin
        ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
      end else if (par_err_q) begin
        perr_nxt = 1'b1;
`endif
      end else begin
        done_nxt = 1'b1;
      end
    end
  end

  // Result stage: pulses and the delivered word
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Rx_Done   <= 1'b0;
      Frame_Err <= 1'b0;
      data_byte <= '0;
    end else begin
      Rx_Done   <= done_nxt;
      Frame_Err <= ferr_nxt;
      if (done_nxt) data_byte <= shift_reg;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge Clk) begin
    if (Rst) Parity_Err <= 1'b0;
    else     Parity_Err <= perr_nxt;
  end
`else
  assign Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int BIT8 = 432;   // 27 * 16 at 115200
  localparam int BIT5 = 5200;  // 325 * 16 at 9600

`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_FERR = 3'b010;
  localparam logic [2:0] K_PERR = 3'b100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst5, parity_odd, rx, rx5;
  logic [2:0] baud_set, baud5;
  logic [7:0] data8;
  logic [4:0] data5;
  logic       done8, ferr8, perr8, busy8;
  logic       done5, ferr5, perr5, busy5;

  uart_rx_param #(.CLK_FREQ(50_000_000), .DATA_BITS(8), .OVERSAMPLE(16)) u_dut8 (
    .Clk(clk), .Rst(rst), .baud_set(baud_set), .parity_odd(parity_odd),
    .Rs232_Rx(rx), .data_byte(data8), .Rx_Done(done8), .Frame_Err(ferr8),
    .Parity_Err(perr8), .Rx_Busy(busy8)
  );

  uart_rx_param #(.CLK_FREQ(50_000_000), .DATA_BITS(5), .OVERSAMPLE(16)) u_dut5 (
    .Clk(clk), .Rst(rst5), .baud_set(baud5), .parity_odd(parity_odd),
    .Rs232_Rx(rx5), .data_byte(data5), .Rx_Done(done5), .Frame_Err(ferr5),
    .Parity_Err(perr5), .Rx_Busy(busy5)
  );

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
  } vec_t;

  exp_t q[$];
  exp_t q5[$];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic push8(input logic [2:0] kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx = v;
    else          rx5 = v;
  endtask

  // Ideal transmitter. rst_bit >= 0 pulses rst for one cycle mid-way through that data bit.
  task automatic send(input int sel, input logic [8:0] data, input int nbits,
                      input int bitlen, input bit stop_val, input bit par_en,
                      input bit par_val, input int rst_bit);
    drive(sel, 1'b0);
    wait_clk(bitlen);
    for (int i = 0; i < nbits; i++) begin
      drive(sel, data[i]);
      if (i == rst_bit) begin
        wait_clk(bitlen / 2);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", {24'd0, data8}, 32'h0);
        check("rst_busy", {31'd0, busy8}, 32'h0);
        check("rst_pulses", {29'd0, perr8, ferr8, done8}, 32'h0);
        wait_clk(bitlen - bitlen / 2 - 1);
      end else begin
        wait_clk(bitlen);
      end
    end
    if (par_en) begin
      drive(sel, par_val);
      wait_clk(bitlen);
    end
    drive(sel, stop_val);
    wait_clk(bitlen);
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8 | ferr8 | perr8) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pulse8_unexpected: got kind=%b data=%0h expected none", {perr8, ferr8, done8}, data8);
      end else begin
        e = q.pop_front();
        if ({perr8, ferr8, done8} !== e.kind || data8 !== e.data) begin
          bad++;
          $display("FAIL pulse8: got kind=%b data=%0h expected kind=%b data=%0h",
                   {perr8, ferr8, done8}, data8, e.kind, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin : mon5
    exp_t e;
    if (done5 | ferr5 | perr5) begin
      total++;
      if (q5.size() == 0) begin
        bad++;
        $display("FAIL pulse5_unexpected: got kind=%b data=%0h expected none", {perr5, ferr5, done5}, data5);
      end else begin
        e = q5.pop_front();
        if ({perr5, ferr5, done5} !== e.kind || data5 !== e.data[4:0]) begin
          bad++;
          $display("FAIL pulse5: got kind=%b data=%0h expected kind=%b data=%0h",
                   {perr5, ferr5, done5}, data5, e.kind, e.data[4:0]);
        end
      end
    end
  end

  task automatic main_seq();
    vec_t vecs[5];
    vecs = '{'{8'hAA, 1'b1}, '{8'h55, 1'b1}, '{8'h00, 1'b1}, '{8'hFF, 1'b1}, '{8'h3C, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].stop_ok) begin
        push8(K_DONE, vecs[i].data);
        last_good = vecs[i].data;
      end else begin
        push8(K_FERR, last_good);
      end
      send(0, {1'b0, vecs[i].data}, 8, BIT8, vecs[i].stop_ok, PAR, ^vecs[i].data, -1);
      if (!vecs[i].stop_ok) begin
        // Line stays low after the bad stop bit; must not retrigger.
        wait_clk(2000);
        @(negedge clk);
        check("ferr_hold_busy", {31'd0, busy8}, 32'h0);
        check("ferr_hold_data", {24'd0, data8}, {24'd0, last_good});
        rx = 1'b1;
        wait_clk(500);
      end
    end

    // 100-cycle low glitch: false start.
    rx = 1'b0;
    wait_clk(100);
    rx = 1'b1;
    wait_clk(50);
    @(negedge clk);
    check("glitch_busy_hi", {31'd0, busy8}, 32'h1);
    wait_clk(300);
    @(negedge clk);
    check("glitch_busy_lo", {31'd0, busy8}, 32'h0);
    check("glitch_data", {24'd0, data8}, {24'd0, last_good});

    // Reset in the high half of 8'hF0's data bits aborts the frame.
    send(0, 9'h0F0, 8, BIT8, 1'b1, PAR, ^8'hF0, 5);
    last_good = 8'h00;
    wait_clk(500);
    check("post_rst_busy", {31'd0, busy8}, 32'h0);

    push8(K_DONE, 8'h81);
    last_good = 8'h81;
    send(0, 9'h081, 8, BIT8, 1'b1, PAR, ^8'h81, -1);
    wait_clk(500);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    push8(K_PERR, last_good);
    send(0, 9'h007, 8, BIT8, 1'b1, 1'b1, 1'b0, -1);
    push8(K_DONE, 8'h07);
    last_good = 8'h07;
    send(0, 9'h007, 8, BIT8, 1'b1, 1'b1, 1'b1, -1);
    wait_clk(500);
`endif
    @(negedge clk);
    check("final_data8", {24'd0, data8}, {24'd0, last_good});
  endtask

  task automatic five_seq();
    exp_t e;
    e.kind = K_DONE;
    e.data = 8'h15;
    q5.push_back(e);
    fork
      send(1, 9'h015, 5, BIT5, 1'b1, PAR, ^5'h15, -1);
      begin
        wait_clk(BIT5 * 2);
        baud5 = 3'd4;
        wait_clk(BIT5);
        baud5 = 3'd2;
        wait_clk(BIT5);
        baud5 = 3'd7;
      end
    join
    wait_clk(500);
    @(negedge clk);
    check("final_data5", {27'd0, data5}, 32'h15);
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rst5 = 1'b1; rx = 1'b1; rx5 = 1'b1;
    baud_set = 3'd4; baud5 = 3'd0; parity_odd = 1'b0;
    wait_clk(5);
    rst = 1'b0; rst5 = 1'b0;
    @(negedge clk);
    check("reset_data", {24'd0, data8}, 32'h0);
    check("reset_done", {31'd0, done8}, 32'h0);
    check("reset_ferr", {31'd0, ferr8}, 32'h0);
    check("reset_perr", {31'd0, perr8}, 32'h0);
    check("reset_busy", {31'd0, busy8}, 32'h0);
    fork
      main_seq();
      five_seq();
    join
    wait_clk(200);
    check("q8_drained", q.size(), 32'h0);
    check("q5_drained", q5.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
